// File: rtl/wb_regfile.sv
// wb_regfile: writeback select plus 32-entry register file with two bypassed read ports.
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel_wb,
    input  logic          reg_rw,
    input  logic [AW-1:0] addr_dst,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] data_out,
    input  logic [AW-1:0] addr_rs,
    input  logic [AW-1:0] addr_rt,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [DW-1:0] wb_data,
    output logic          wb_valid
);
    logic [DW-1:0] regs [2**AW];
    assign wb_data  = sel_wb ? data_out : alu_result;
    assign wb_valid = reg_rw && (addr_dst != '0);
    always_ff @(posedge clk or negedge rst)
        if (!rst) for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
        else if (wb_valid) regs[addr_dst] <= wb_data;
    // Reset also masks the bypass path so reads are zero while rst is low.
    assign rs_data = (!rst || addr_rs == '0) ? '0 :
                     (wb_valid && addr_dst == addr_rs) ? wb_data : regs[addr_rs];
    assign rt_data = (!rst || addr_rt == '0) ? '0 :
                     (wb_valid && addr_dst == addr_rt) ? wb_data : regs[addr_rt];
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel_wb = 1'b0;
    logic        reg_rw = 1'b0;
    logic [4:0]  addr_dst = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] data_out = '0;
    logic [4:0]  addr_rs = '0;
    logic [4:0]  addr_rt = '0;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_valid;
    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst), .sel_wb(sel_wb), .reg_rw(reg_rw), .addr_dst(addr_dst),
        .alu_result(alu_result), .data_out(data_out), .addr_rs(addr_rs), .addr_rt(addr_rt),
        .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("reset_rs", rs_data, 32'h0);
        chk("reset_rt", rt_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        // ALU result and load data selection
        reg_rw = 1'b1; sel_wb = 1'b0; addr_dst = 5'd5;
        alu_result = 32'h1234_5678; data_out = 32'hDEAD_BEEF;
        #1;
        chk("wb_data_alu", wb_data, 32'h1234_5678);
        chk("wb_valid_5", {31'b0, wb_valid}, 32'h1);
        tick;
        sel_wb = 1'b1; addr_dst = 5'd6; addr_rs = 5'd5;
        #1;
        chk("wb_data_load", wb_data, 32'hDEAD_BEEF);
        chk("reg5", rs_data, 32'h1234_5678);
        tick;
        reg_rw = 1'b0; addr_rs = 5'd6; addr_rt = 5'd5;
        #1;
        chk("reg6", rs_data, 32'hDEAD_BEEF);
        chk("reg5_rt", rt_data, 32'h1234_5678);
        // writes to register 0 are discarded
        reg_rw = 1'b1; sel_wb = 1'b0; addr_dst = 5'd0; alu_result = 32'hFFFF_FFFF; addr_rs = 5'd0;
        #1;
        chk("wb_valid_r0_pre", {31'b0, wb_valid}, 32'h0);
        chk("r0_bypass", rs_data, 32'h0);
        tick;
        chk("wb_valid_r0_post", {31'b0, wb_valid}, 32'h0);
        reg_rw = 1'b0;
        #1;
        chk("r0_after", rs_data, 32'h0);
        // same-cycle bypass on both ports
        reg_rw = 1'b1; addr_dst = 5'd7; alu_result = 32'h1;
        tick;
        reg_rw = 1'b0; addr_rs = 5'd7; addr_rt = 5'd7;
        #1;
        chk("reg7_old", rs_data, 32'h1);
        reg_rw = 1'b1; alu_result = 32'hA5A5_A5A5;
        #1;
        chk("bypass_rs", rs_data, 32'hA5A5_A5A5);
        chk("bypass_rt", rt_data, 32'hA5A5_A5A5);
        tick;
        reg_rw = 1'b0; alu_result = 32'h0;
        #1;
        chk("reg7_new_rs", rs_data, 32'hA5A5_A5A5);
        chk("reg7_new_rt", rt_data, 32'hA5A5_A5A5);
        // disabled write: no state change, no bypass, wb_data still follows
        reg_rw = 1'b0; addr_dst = 5'd9; alu_result = 32'h55; addr_rs = 5'd9;
        #1;
        chk("nowr_bypass", rs_data, 32'h0);
        chk("nowr_wb_data", wb_data, 32'h55);
        chk("nowr_valid", {31'b0, wb_valid}, 32'h0);
        tick;
        chk("nowr_reg9", rs_data, 32'h0);
        // fill all nonzero registers, then read back
        reg_rw = 1'b1; sel_wb = 1'b0;
        for (int i = 1; i < 32; i++) begin
            addr_dst = 5'(i);
            alu_result = i * 32'h0101_0101;
            tick;
        end
        reg_rw = 1'b0;
        for (int i = 1; i < 32; i++) begin
            addr_rs = 5'(i);
            addr_rt = 5'(32 - i);
            #1;
            chk($sformatf("fill_rs%0d", i), rs_data, i * 32'h0101_0101);
            chk($sformatf("fill_rt%0d", 32 - i), rt_data, (32 - i) * 32'h0101_0101);
        end
        // asynchronous reset mid-cycle clears everything immediately
        addr_rs = 5'd5; addr_rt = 5'd31;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rs", rs_data, 32'h0);
        chk("async_rt", rt_data, 32'h0);
        reg_rw = 1'b1; addr_dst = 5'd3; alu_result = 32'h77; addr_rs = 5'd3;
        #1;
        chk("rst_bypass_masked", rs_data, 32'h0);
        tick;
        rst = 1'b1; reg_rw = 1'b0;
        #1;
        chk("rst_no_write", rs_data, 32'h0);
        addr_rt = 5'd31;
        #1;
        chk("post_rst_r31", rt_data, 32'h0);
        tick;
        chk("post_rst_r3", rs_data, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
